// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring-divide step per clock, WIDTH steps
// per operation. Optional macro MDU_SIGNED_EN enables signed MULT/DIV
// (op[1] = 1); without it op[1] is ignored and every operation is unsigned.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;
    logic             w_mt_ok;

    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_acc_hi;   // partial product high / running remainder
    logic [WIDTH-1:0] r_acc_lo;   // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] r_a_raw;    // original dividend, returned on divide by zero
    logic             r_b_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

`ifdef MDU_SIGNED_EN
    logic             w_a_neg;
    logic             w_b_neg;
    logic             r_neg_res;  // product/quotient sign differs from magnitude
    logic             r_neg_a;    // remainder follows the dividend's sign

    assign w_a_neg = op[1] & a[WIDTH-1];
    assign w_b_neg = op[1] & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
`else
    logic             w_unused_op_sign;

    assign w_unused_op_sign = op[1];
    assign w_a_mag          = a;
    assign w_b_mag          = b;
`endif

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, operation acceptance and MTHI/MTLO qualification
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_mt_ok     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_accept    = start;
                w_mt_ok     = !start;
                w_state_nxt = start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                w_last = (r_cnt == LAST_STEP);
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_acc_hi_nxt;
    logic [WIDTH-1:0] w_acc_lo_nxt;

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
        w_rem_sh = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_ge     = (w_rem_sh >= {1'b0, r_opnd});
        w_diff   = w_rem_sh - {1'b0, r_opnd};
        if (r_is_div) begin
            w_acc_hi_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            w_acc_lo_nxt = {r_acc_lo[WIDTH-2:0], w_ge};
        end else begin
            w_acc_hi_nxt = w_sum[WIDTH:1];
            w_acc_lo_nxt = {w_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Final HI/LO values from the last iteration, with sign and zero fix-ups
    always_comb begin
        w_prod   = {w_acc_hi_nxt, w_acc_lo_nxt};
        w_res_hi = w_acc_hi_nxt;
        w_res_lo = w_acc_lo_nxt;
        if (!r_is_div) begin
`ifdef MDU_SIGNED_EN
            if (r_neg_res) begin
                w_prod = -{w_acc_hi_nxt, w_acc_lo_nxt};
            end
`endif
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end else if (r_b_zero) begin
            w_res_hi = r_a_raw;
            w_res_lo = '1;
        end else begin
`ifdef MDU_SIGNED_EN
            // -2^(WIDTH-1) / -1 needs no special case: the magnitude quotient
            // is 2^(WIDTH-1), signs agree, so it passes through unchanged.
            if (r_neg_res) begin
                w_res_lo = -w_acc_lo_nxt;
            end
            if (r_neg_a) begin
                w_res_hi = -w_acc_hi_nxt;
            end
`endif
        end
    end

    // Operand capture, iteration registers and the architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_opnd    <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_a_raw   <= '0;
            r_b_zero  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dbz     <= 1'b0;
`ifdef MDU_SIGNED_EN
            r_neg_res <= 1'b0;
            r_neg_a   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_cnt     <= '0;
                r_is_div  <= op[0];
                r_opnd    <= op[0] ? w_b_mag : w_a_mag;
                r_acc_hi  <= '0;
                r_acc_lo  <= op[0] ? w_a_mag : w_b_mag;
                r_a_raw   <= a;
                r_b_zero  <= (b == '0);
                r_dbz     <= 1'b0;
`ifdef MDU_SIGNED_EN
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_a   <= w_a_neg;
`endif
            end else if (r_state == S_RUN) begin
                r_cnt    <= r_cnt + 1'b1;
                r_acc_hi <= w_acc_hi_nxt;
                r_acc_lo <= w_acc_lo_nxt;
                if (w_last) begin
                    r_hi  <= w_res_hi;
                    r_lo  <= w_res_lo;
                    r_dbz <= r_is_div & r_b_zero;
                end
            end
            // MTHI/MTLO only land when no operation is running or starting
            if (w_mt_ok && hi_wr) begin
                r_hi <= wr_data;
            end
            if (w_mt_ok && lo_wr) begin
                r_lo <= wr_data;
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed bench for mult_div_unit.
// Expected HI/LO come from 64-bit integer arithmetic on the operands.
// Honors MDU_SIGNED_EN the same way the design does.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_wr;
    logic         lo_wr;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected architectural state tracked by the bench
    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;
    logic         m_dbz = 1'b0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_wr       (hi_wr),
        .lo_wr       (lo_wr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer multiply/divide
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] eh,
                                  output logic [W-1:0] el, output logic ed);
        bit          sgn;
        longint      sx;
        longint      sy;
        logic [63:0] bits;
`ifdef MDU_SIGNED_EN
        sgn = o[1];
`else
        sgn = 1'b0;
`endif
        sx = sgn ? longint'($signed(x)) : longint'({32'b0, x});
        sy = sgn ? longint'($signed(y)) : longint'({32'b0, y});
        ed = 1'b0;
        if (!o[0]) begin
            bits = sx * sy;
            eh   = bits[63:32];
            el   = bits[31:0];
        end else if (y == '0) begin
            eh = x;
            el = '1;
            ed = 1'b1;
        end else begin
            bits = sx / sy;
            el   = bits[31:0];
            bits = sx % sy;
            eh   = bits[31:0];
        end
    endfunction

    // Issue one operation from IDLE/DONE (called #1 after a clock edge) and
    // check latency, busy duration, HI/LO hold during RUN, and the result.
    // poke: RUN sample index at which start/hi_wr/lo_wr are pulsed (0 = never).
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit hold_done, input int poke, input bit wr_with_start);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         ed;
        int           n;
        int           nbusy;
        int           nhold;
        model(o, x, y, eh, el, ed);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (wr_with_start) begin
            hi_wr   = 1'b1;
            lo_wr   = 1'b1;
            wr_data = $urandom;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom_range(3));
        check("dbz_clear_on_start", 64'(div_by_zero), 64'(0));
        n     = 1;
        nbusy = 0;
        nhold = 0;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) nbusy++;
            if (hi !== m_hi || lo !== m_lo) nhold++;
            if (poke != 0 && n == poke) begin
                start   = 1'b1;
                hi_wr   = 1'b1;
                lo_wr   = 1'b1;
                wr_data = $urandom;
            end else begin
                start = 1'b0;
                hi_wr = 1'b0;
                lo_wr = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        m_hi  = eh;
        m_lo  = el;
        m_dbz = ed;
        check("latency_edges", 64'(n), 64'(W + 1));
        check("busy_cycles", 64'(nbusy), 64'(W));
        check("hold_during_run", 64'(nhold), 64'(0));
        check("busy_low_at_done", 64'(busy), 64'(0));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        if (!hold_done) begin
            @(posedge clk);
            #1;
            check("done_one_cycle", 64'(done), 64'(0));
        end
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [1:0]   o;
        int           nd;
        int           sel;

        reset   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        hi_wr   = 1'b0;
        lo_wr   = 1'b0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo", 64'(lo), 64'h0000_0001);
        do_op(2'b01, 32'd100, 32'd7, 1'b1, 0, 1'b0);        // back-to-back follows
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, 0, 1'b0);
        do_op(2'b01, 32'h0000_1234, 32'd0, 1'b0, 0, 1'b0);
        check("divu_zero_dbz", 64'(div_by_zero), 64'(1));
        do_op(2'b00, 32'd3, 32'd4, 1'b0, 0, 1'b0);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        do_op(2'b11, 32'hFFFF_FFF0, 32'd0, 1'b0, 0, 1'b0);
        do_op(2'b00, 32'h0001_2345, 32'h0006_789A, 1'b0, 5, 1'b1);

        // MTHI / MTLO from IDLE
        wr_data = 32'hCAFE_0001;
        hi_wr   = 1'b1;
        @(posedge clk);
        #1;
        hi_wr = 1'b0;
        m_hi  = 32'hCAFE_0001;
        check("mthi_hi", 64'(hi), 64'(m_hi));
        check("mthi_lo_keep", 64'(lo), 64'(m_lo));
        wr_data = 32'hBEEF_0002;
        lo_wr   = 1'b1;
        @(posedge clk);
        #1;
        lo_wr = 1'b0;
        m_lo  = 32'hBEEF_0002;
        check("mtlo_lo", 64'(lo), 64'(m_lo));
        check("mtlo_hi_keep", 64'(hi), 64'(m_hi));
        wr_data = 32'h1357_9BDF;
        hi_wr   = 1'b1;
        lo_wr   = 1'b1;
        @(posedge clk);
        #1;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        m_hi  = 32'h1357_9BDF;
        m_lo  = 32'h1357_9BDF;
        check("mt_both_hi", 64'(hi), 64'(m_hi));
        check("mt_both_lo", 64'(lo), 64'(m_lo));

        // Randomized operations, some back-to-back, with corner operands mixed in
        for (int i = 0; i < 30; i++) begin
            o   = 2'($urandom_range(3));
            sel = $urandom_range(9);
            x   = $urandom;
            y   = $urandom;
            if (sel == 0) begin
                y = '0;
            end else if (sel == 1) begin
                x = 32'h8000_0000;
                y = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                x = 32'($urandom_range(1000));
                y = 32'($urandom_range(1, 50));
            end else if (sel == 3) begin
                y = 32'($urandom_range(1, 16));
            end
            do_op(o, x, y, (i < 29) ? bit'($urandom_range(1)) : 1'b0, 0, 1'b0);
        end

        // Reset in the middle of a divide aborts it
        op    = 2'b01;
        a     = 32'h0F0F_1234;
        b     = 32'd13;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_dbz", 64'(div_by_zero), 64'(0));
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        m_hi  = '0;
        m_lo  = '0;
        m_dbz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) nd++;
        end
        check("no_done_after_abort", 64'(nd), 64'(0));
        do_op(2'b00, 32'd6, 32'd7, 1'b0, 0, 1'b0);
        check("multu_6x7_lo", 64'(lo), 64'd42);
        check("multu_6x7_hi", 64'(hi), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
